// File: rtl/frame_mem_writer.sv
// frame_mem_writer: stores received Ethernet frame bodies (DA..FCS) into a
// circular packet RAM and queues a {start, length} descriptor for each good
// frame. Bad, runt, oversize or overflowing frames are rolled back.
//
// Ports:
//   iclk, irst_n          clock, async active-low reset
//   i_state/i_data/i_dv   receiver state, byte and byte-valid
//   i_change, i_error     receiver state-change pulse, receiver error
//   i_rcrc                receiver running CRC (checked one cycle after frame end)
//   i_rd_ptr              oldest byte still owned by the reader
//   o_wr_en/addr/data     registered packet RAM write port
//   o_desc_valid/start/len, i_desc_ready   first-word-fall-through descriptor FIFO
//   o_commit_ptr          address after the last committed byte
//   o_frame_cnt/o_drop_cnt saturating committed / dropped frame counters
module frame_mem_writer #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DESC_DEPTH  = 4,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [2:0]        i_state,
  input  logic [7:0]        i_data,
  input  logic              i_dv,
  input  logic              i_change,
  input  logic              i_error,
  input  logic [31:0]       i_rcrc,
  input  logic [ADDR_W-1:0] i_rd_ptr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_desc_valid,
  output logic [ADDR_W-1:0] o_desc_start,
  output logic [10:0]       o_desc_len,
  input  logic              i_desc_ready,
  output logic [ADDR_W-1:0] o_commit_ptr,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt
);

  localparam int unsigned LEN_W  = 11;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PTR_W  = $clog2(DESC_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(64);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1518);
  localparam logic [2:0] RX_NO_FRAME = 3'd0;
  localparam logic [2:0] RX_DA       = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CHECK, S_COMMIT, S_DROP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
  } desc_t;

  state_e state_q, state_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  desc_t             fifo_q [DESC_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_FW-1:0] count_q, count_d;
  desc_t             desc_q, desc_d;
  logic              desc_valid_q, desc_valid_d;

  logic              byte_req_c, no_space_c, fifo_full_c, push_c, pop_c;
  logic [ADDR_W-1:0] free_c;
  desc_t             push_data_c;
  logic              unused_change;

  assign unused_change = i_change;

  // Free space keeps one byte empty so wr_ptr == i_rd_ptr means empty.
  assign free_c      = i_rd_ptr - wr_ptr_q - ADDR_W'(1);
  assign no_space_c  = (free_c == '0);
  assign byte_req_c  = i_dv && (i_state >= RX_DA);
  assign fifo_full_c = (count_q == CNT_FW'(DESC_DEPTH));
  assign pop_c       = desc_valid_q && i_desc_ready;
  assign push_data_c = '{start: start_q, len: len_q};

  // State register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_dv && (i_state == RX_DA)) state_d = no_space_c ? S_DROP : S_WRITE;
      S_WRITE: begin
        if (i_error)                     state_d = S_DROP;
        else if (i_state == RX_NO_FRAME) state_d = S_CHECK;
        else if (byte_req_c && (no_space_c || (len_q == MAX_LEN))) state_d = S_DROP;
      end
      S_CHECK: state_d = ((i_rcrc == CRC_RESIDUE) && (len_q >= MIN_LEN) && !fifo_full_c)
                         ? S_COMMIT : S_DROP;
      S_COMMIT: state_d = S_IDLE;
      S_DROP:   if (i_state == RX_NO_FRAME) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_ptr_d     = wr_ptr_q;
    start_d      = start_q;
    len_d        = len_q;
    commit_ptr_d = commit_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    push_c       = 1'b0;

    // A byte is stored only when the FSM stays in (or enters) WRITE.
    if ((state_d == S_WRITE) && ((state_q == S_IDLE) || byte_req_c)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      wr_data_d = i_data;
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      if (state_q == S_IDLE) begin
        start_d = wr_ptr_q;
        len_d   = LEN_W'(1);
      end else begin
        len_d   = len_q + LEN_W'(1);
      end
    end

    if (state_q == S_COMMIT) begin
      push_c       = 1'b1;
      commit_ptr_d = wr_ptr_q;
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    // Rewind and count once, on entry to DROP.
    if ((state_d == S_DROP) && (state_q != S_DROP)) begin
      wr_ptr_d = commit_ptr_q;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_ptr_q     <= '0;
      start_q      <= '0;
      len_q        <= '0;
      commit_ptr_q <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_ptr_q     <= wr_ptr_d;
      start_q      <= start_d;
      len_q        <= len_d;
      commit_ptr_q <= commit_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Descriptor FIFO next state; head entry is pre-registered for fall-through.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    desc_d = desc_q;
    if (pop_c)  head_d = head_q + PTR_W'(1);
    if (push_c) tail_d = tail_q + PTR_W'(1);
    count_d      = count_q + CNT_FW'(push_c) - CNT_FW'(pop_c);
    desc_valid_d = (count_d != '0);
    // When the stored entries are exhausted only an incoming push can fill the head.
    if (count_q == CNT_FW'(pop_c)) begin
      if (push_c) desc_d = push_data_c;
    end else begin
      desc_d = fifo_q[head_d];
    end
  end

  // Descriptor FIFO registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int unsigned i = 0; i < DESC_DEPTH; i++) fifo_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      desc_q       <= '0;
      desc_valid_q <= 1'b0;
    end else begin
      if (push_c) fifo_q[tail_q] <= push_data_c;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      desc_q       <= desc_d;
      desc_valid_q <= desc_valid_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_desc_valid = desc_valid_q;
  assign o_desc_start = desc_q.start;
  assign o_desc_len   = desc_q.len;
  assign o_commit_ptr = commit_ptr_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_mem_writer.sv
// Bench for frame_mem_writer: a default-size instance (u_big) and a 128-byte
// instance (u_small) share the receiver stimulus. Expected RAM writes and
// descriptors are queued as frames are driven and consumed by monitors.
`timescale 1ns/1ps
module tb_frame_mem_writer;

  localparam logic [31:0] RES = 32'hC704DD7B;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [2:0]  i_state;
  logic [7:0]  i_data;
  logic        i_dv, i_change, i_error, i_desc_ready;
  logic [31:0] i_rcrc;
  logic [10:0] rd_b;
  logic [6:0]  rd_s;

  logic        b_wr_en, b_desc_valid;
  logic [10:0] b_wr_addr, b_desc_start, b_desc_len, b_commit_ptr;
  logic [7:0]  b_wr_data;
  logic [15:0] b_frame_cnt, b_drop_cnt;

  logic        s_wr_en, s_desc_valid;
  logic [6:0]  s_wr_addr, s_desc_start, s_commit_ptr;
  logic [10:0] s_desc_len;
  logic [7:0]  s_wr_data;
  logic [15:0] s_frame_cnt, s_drop_cnt;

  logic [18:0] exp_wb_q[$], exp_ws_q[$];
  logic [21:0] exp_db_q[$], exp_ds_q[$];
  logic [18:0] wexp_b, wexp_s;
  logic [21:0] dexp_b, dexp_s;
  int          checks = 0;
  int          errors = 0;
  bit          mon_b, mon_s;

  always #5 iclk = ~iclk;

  frame_mem_writer u_big (
    .iclk(iclk), .irst_n(irst_n), .i_state(i_state), .i_data(i_data), .i_dv(i_dv),
    .i_change(i_change), .i_error(i_error), .i_rcrc(i_rcrc), .i_rd_ptr(rd_b),
    .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
    .o_desc_valid(b_desc_valid), .o_desc_start(b_desc_start), .o_desc_len(b_desc_len),
    .i_desc_ready(i_desc_ready), .o_commit_ptr(b_commit_ptr),
    .o_frame_cnt(b_frame_cnt), .o_drop_cnt(b_drop_cnt)
  );

  frame_mem_writer #(.ADDR_W(7)) u_small (
    .iclk(iclk), .irst_n(irst_n), .i_state(i_state), .i_data(i_data), .i_dv(i_dv),
    .i_change(i_change), .i_error(i_error), .i_rcrc(i_rcrc), .i_rd_ptr(rd_s),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
    .o_desc_valid(s_desc_valid), .o_desc_start(s_desc_start), .o_desc_len(s_desc_len),
    .i_desc_ready(i_desc_ready), .o_commit_ptr(s_commit_ptr),
    .o_frame_cnt(s_frame_cnt), .o_drop_cnt(s_drop_cnt)
  );

  // Scoreboard monitor for the default-size instance.
  always @(negedge iclk) begin
    if (irst_n && mon_b) begin
      if (b_wr_en) begin
        checks++;
        if (exp_wb_q.size() == 0) begin
          errors++;
          $display("FAIL wr_big: got write addr=%0d data=%02h, required no write", b_wr_addr, b_wr_data);
        end else begin
          wexp_b = exp_wb_q.pop_front();
          if ({b_wr_addr, b_wr_data} !== wexp_b) begin
            errors++;
            $display("FAIL wr_big: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     b_wr_addr, b_wr_data, wexp_b[18:8], wexp_b[7:0]);
          end
        end
      end
      if (b_desc_valid && i_desc_ready) begin
        checks++;
        if (exp_db_q.size() == 0) begin
          errors++;
          $display("FAIL desc_big: got {%0d,%0d}, required no descriptor", b_desc_start, b_desc_len);
        end else begin
          dexp_b = exp_db_q.pop_front();
          if ({b_desc_start, b_desc_len} !== dexp_b) begin
            errors++;
            $display("FAIL desc_big: got {%0d,%0d}, required {%0d,%0d}",
                     b_desc_start, b_desc_len, dexp_b[21:11], dexp_b[10:0]);
          end
        end
      end
    end
  end

  // Scoreboard monitor for the 128-byte instance.
  always @(negedge iclk) begin
    if (irst_n && mon_s) begin
      if (s_wr_en) begin
        checks++;
        if (exp_ws_q.size() == 0) begin
          errors++;
          $display("FAIL wr_small: got write addr=%0d data=%02h, required no write", s_wr_addr, s_wr_data);
        end else begin
          wexp_s = exp_ws_q.pop_front();
          if ({4'd0, s_wr_addr, s_wr_data} !== wexp_s) begin
            errors++;
            $display("FAIL wr_small: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     s_wr_addr, s_wr_data, wexp_s[18:8], wexp_s[7:0]);
          end
        end
      end
      if (s_desc_valid && i_desc_ready) begin
        checks++;
        if (exp_ds_q.size() == 0) begin
          errors++;
          $display("FAIL desc_small: got {%0d,%0d}, required no descriptor", s_desc_start, s_desc_len);
        end else begin
          dexp_s = exp_ds_q.pop_front();
          if ({4'd0, s_desc_start, s_desc_len} !== dexp_s) begin
            errors++;
            $display("FAIL desc_small: got {%0d,%0d}, required {%0d,%0d}",
                     s_desc_start, s_desc_len, dexp_s[21:11], dexp_s[10:0]);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] rx_state(input int i, input int n);
    if (i < 6)       return 3'd3;
    if (i < 12)      return 3'd4;
    if (i < 14)      return 3'd5;
    if (i >= n - 4)  return 3'd7;
    return 3'd6;
  endfunction

  // Drives one frame; the first nwr_b / nwr_s bytes are expected in RAM at base_b / base_s.
  // The receiver CRC is modelled: it shows the residue at frame end only when good=1.
  task automatic drive_frame(input int n, input bit good, input int err_at,
                             input int nwr_b, input logic [10:0] base_b,
                             input int nwr_s, input logic [6:0] base_s);
    logic [7:0] d;
    logic [2:0] prev;
    prev = 3'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge iclk); #1;
      d        = 8'($urandom);
      i_data   = d;
      i_dv     = 1'b1;
      i_state  = rx_state(i, n);
      i_change = (i_state != prev);
      prev     = i_state;
      i_error  = (i == err_at);
      i_rcrc   = $urandom;
      if (i < nwr_b) exp_wb_q.push_back({11'(base_b + 11'(i)), d});
      if (i < nwr_s) exp_ws_q.push_back({4'd0, 7'(base_s + 7'(i)), d});
    end
    @(posedge iclk); #1;
    i_state  = 3'd0;
    i_dv     = 1'b0;
    i_error  = 1'b0;
    i_change = 1'b1;
    i_rcrc   = good ? RES : ~RES;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk); #1;
      i_change = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge iclk); #1;
    irst_n = 1'b0;
    i_state = 3'd0; i_data = 8'd0; i_dv = 1'b0; i_change = 1'b0; i_error = 1'b0;
    i_rcrc = 32'd0; rd_b = 11'd0; rd_s = 7'd0; i_desc_ready = 1'b1;
    mon_b = 1'b0; mon_s = 1'b0;
    exp_wb_q.delete(); exp_ws_q.delete(); exp_db_q.delete(); exp_ds_q.delete();
    repeat (3) @(posedge iclk);
    #1 irst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({b_wr_en, b_desc_valid, b_wr_addr, b_wr_data, b_desc_start, b_desc_len,
         b_commit_ptr, b_frame_cnt, b_drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got wr_en=%b valid=%b addr=%0d commit=%0d frames=%0d drops=%0d, required all 0",
               b_wr_en, b_desc_valid, b_wr_addr, b_commit_ptr, b_frame_cnt, b_drop_cnt);
    end
    // Reset in the middle of a frame.
    fork
      drive_frame(64, 1'b1, -1, 0, 11'd0, 0, 7'd0);
      begin
        repeat (30) @(posedge iclk);
        #2;
        checks++;
        if (b_wr_en !== 1'b1) begin
          errors++;
          $display("FAIL midframe_writing: got wr_en=%b, required 1", b_wr_en);
        end
        irst_n = 1'b0;
        #1;
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data} !== '0) begin
          errors++;
          $display("FAIL midframe_reset: got wr_en=%b addr=%0d data=%02h, required 0", b_wr_en, b_wr_addr, b_wr_data);
        end
      end
    join
    @(posedge iclk); #1 irst_n = 1'b1;
    idle(3);
    mon_b = 1'b1;
    exp_db_q.push_back({11'd0, 11'd64});
    drive_frame(64, 1'b1, -1, 64, 11'd0, 0, 7'd0);
    idle(8);
    checks++;
    if (b_commit_ptr !== 11'd64 || b_frame_cnt !== 16'd1 || exp_wb_q.size() != 0 || exp_db_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_frame: got commit=%0d frames=%0d pend_wr=%0d pend_desc=%0d, required 64 1 0 0",
               b_commit_ptr, b_frame_cnt, exp_wb_q.size(), exp_db_q.size());
    end
  endtask

  task automatic test_good();
    do_reset();
    mon_b = 1'b1;
    exp_db_q.push_back({11'd0, 11'd64});
    drive_frame(64, 1'b1, -1, 64, 11'd0, 0, 7'd0);
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    checks++;
    if (b_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL commit_latency_early: got valid=%b, required 0", b_desc_valid);
    end
    @(posedge iclk);
    @(negedge iclk);
    checks++;
    if (b_desc_valid !== 1'b1 || b_commit_ptr !== 11'd64) begin
      errors++;
      $display("FAIL commit_latency: got valid=%b commit=%0d, required 1 64", b_desc_valid, b_commit_ptr);
    end
    idle(4);
    checks++;
    if (b_frame_cnt !== 16'd1 || b_drop_cnt !== 16'd0 || exp_wb_q.size() != 0 || exp_db_q.size() != 0) begin
      errors++;
      $display("FAIL good_frame: got frames=%0d drops=%0d pend_wr=%0d pend_desc=%0d, required 1 0 0 0",
               b_frame_cnt, b_drop_cnt, exp_wb_q.size(), exp_db_q.size());
    end
  endtask

  task automatic test_bad_fcs();
    do_reset();
    mon_b = 1'b1;
    drive_frame(64, 1'b0, -1, 64, 11'd0, 0, 7'd0);
    idle(6);
    checks++;
    if (b_drop_cnt !== 16'd1 || b_frame_cnt !== 16'd0 || b_commit_ptr !== 11'd0 || b_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_fcs: got drops=%0d frames=%0d commit=%0d valid=%b, required 1 0 0 0",
               b_drop_cnt, b_frame_cnt, b_commit_ptr, b_desc_valid);
    end
    exp_db_q.push_back({11'd0, 11'd64});
    drive_frame(64, 1'b1, -1, 64, 11'd0, 0, 7'd0);
    idle(6);
    checks++;
    if (b_frame_cnt !== 16'd1 || b_commit_ptr !== 11'd64 || exp_wb_q.size() != 0 || exp_db_q.size() != 0) begin
      errors++;
      $display("FAIL after_bad_fcs: got frames=%0d commit=%0d pend_wr=%0d pend_desc=%0d, required 1 64 0 0",
               b_frame_cnt, b_commit_ptr, exp_wb_q.size(), exp_db_q.size());
    end
  endtask

  task automatic test_runt();
    do_reset();
    mon_b = 1'b1;
    exp_db_q.push_back({11'd0, 11'd64});
    drive_frame(64, 1'b1, -1, 64, 11'd0, 0, 7'd0);
    idle(6);
    drive_frame(40, 1'b1, -1, 40, 11'd64, 0, 7'd0);
    idle(6);
    checks++;
    if (b_commit_ptr !== 11'd64 || b_drop_cnt !== 16'd1 || b_frame_cnt !== 16'd1 ||
        exp_wb_q.size() != 0 || exp_db_q.size() != 0) begin
      errors++;
      $display("FAIL runt: got commit=%0d drops=%0d frames=%0d pend_wr=%0d pend_desc=%0d, required 64 1 1 0 0",
               b_commit_ptr, b_drop_cnt, b_frame_cnt, exp_wb_q.size(), exp_db_q.size());
    end
  endtask

  task automatic test_error();
    do_reset();
    mon_b = 1'b1;
    drive_frame(100, 1'b1, 20, 20, 11'd0, 0, 7'd0);
    idle(4);
    checks++;
    if (b_drop_cnt !== 16'd1 || b_commit_ptr !== 11'd0 || b_desc_valid !== 1'b0 || exp_wb_q.size() != 0) begin
      errors++;
      $display("FAIL error_abort: got drops=%0d commit=%0d valid=%b pend_wr=%0d, required 1 0 0 0",
               b_drop_cnt, b_commit_ptr, b_desc_valid, exp_wb_q.size());
    end
    exp_db_q.push_back({11'd0, 11'd64});
    drive_frame(64, 1'b1, -1, 64, 11'd0, 0, 7'd0);
    idle(6);
    checks++;
    if (b_commit_ptr !== 11'd64 || b_frame_cnt !== 16'd1 || b_drop_cnt !== 16'd1 ||
        exp_wb_q.size() != 0 || exp_db_q.size() != 0) begin
      errors++;
      $display("FAIL after_error: got commit=%0d frames=%0d drops=%0d, required 64 1 1",
               b_commit_ptr, b_frame_cnt, b_drop_cnt);
    end
  endtask

  task automatic test_overflow_wrap();
    do_reset();
    mon_s = 1'b1;
    exp_ds_q.push_back({11'd0, 11'd100});
    drive_frame(100, 1'b1, -1, 0, 11'd0, 100, 7'd0);
    idle(6);
    checks++;
    if (s_commit_ptr !== 7'd100 || s_frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL small_first: got commit=%0d frames=%0d, required 100 1", s_commit_ptr, s_frame_cnt);
    end
    // Only 27 bytes fit before free space reaches zero.
    drive_frame(64, 1'b1, -1, 0, 11'd0, 27, 7'd100);
    idle(6);
    checks++;
    if (s_drop_cnt !== 16'd1 || s_commit_ptr !== 7'd100 || s_frame_cnt !== 16'd1 || exp_ws_q.size() != 0) begin
      errors++;
      $display("FAIL overflow: got drops=%0d commit=%0d frames=%0d pend_wr=%0d, required 1 100 1 0",
               s_drop_cnt, s_commit_ptr, s_frame_cnt, exp_ws_q.size());
    end
    rd_s = 7'd100;
    exp_ds_q.push_back({11'd100, 11'd64});
    drive_frame(64, 1'b1, -1, 0, 11'd0, 64, 7'd100);
    idle(6);
    checks++;
    if (s_commit_ptr !== 7'd36 || s_frame_cnt !== 16'd2 || exp_ws_q.size() != 0 || exp_ds_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got commit=%0d frames=%0d pend_wr=%0d pend_desc=%0d, required 36 2 0 0",
               s_commit_ptr, s_frame_cnt, exp_ws_q.size(), exp_ds_q.size());
    end
  endtask

  task automatic test_back_to_back_fifo_full();
    do_reset();
    mon_b = 1'b1;
    i_desc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_db_q.push_back({11'(64 * k), 11'd64});
      drive_frame(64, 1'b1, -1, 64, 11'(64 * k), 0, 7'd0);
      idle(7);
    end
    idle(2);
    checks++;
    if (b_frame_cnt !== 16'd4 || b_drop_cnt !== 16'd1 || b_commit_ptr !== 11'd256) begin
      errors++;
      $display("FAIL fifo_full: got frames=%0d drops=%0d commit=%0d, required 4 1 256",
               b_frame_cnt, b_drop_cnt, b_commit_ptr);
    end
    checks++;
    if (b_desc_valid !== 1'b1 || b_desc_start !== 11'd0 || b_desc_len !== 11'd64) begin
      errors++;
      $display("FAIL fifo_head: got valid=%b {%0d,%0d}, required 1 {0,64}", b_desc_valid, b_desc_start, b_desc_len);
    end
    i_desc_ready = 1'b1;
    idle(8);
    checks++;
    if (b_desc_valid !== 1'b0 || exp_db_q.size() != 0 || exp_wb_q.size() != 0) begin
      errors++;
      $display("FAIL fifo_drain: got valid=%b pend_desc=%0d pend_wr=%0d, required 0 0 0",
               b_desc_valid, exp_db_q.size(), exp_wb_q.size());
    end
  endtask

  initial begin
    irst_n = 1'b0;
    mon_b = 1'b0;
    mon_s = 1'b0;
    test_reset();
    test_good();
    test_bad_fcs();
    test_runt();
    test_error();
    test_overflow_wrap();
    test_back_to_back_fifo_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
